// File: rtl/exc_ctrl_if.sv
// Exception controller signal bundle: M-stage status and CP0 link in, pipeline control out.
interface exc_ctrl_if;
  logic [5:0]  hw_irq;
  logic        m_valid;
  logic [4:0]  m_exc_code;
  logic        m_is_eret;
  logic        cp0_go_handle;
  logic [31:0] cp0_epc;
  logic [5:0]  cp0_hwint;
  logic [4:0]  cp0_exccode;
  logic        cp0_exlclr;
  logic        flush;
  logic        kill_m;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] take_count;

  modport master (
    output hw_irq, m_valid, m_exc_code, m_is_eret, cp0_go_handle, cp0_epc,
    input  cp0_hwint, cp0_exccode, cp0_exlclr, flush, kill_m, redirect,
           redirect_pc, take_count
  );

  modport slave (
    input  hw_irq, m_valid, m_exc_code, m_is_eret, cp0_go_handle, cp0_epc,
    output cp0_hwint, cp0_exccode, cp0_exlclr, flush, kill_m, redirect,
           redirect_pc, take_count
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: synchronizes device interrupts, gates them
// to CP0, and redirects the pipeline on exception entry or ERET, followed by
// a short interrupt blackout while the front end refills.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned REFILL_CYC   = 3
) (
  input logic     clk,
  input logic     rst,
  exc_ctrl_if.slave bus
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;
  localparam logic [3:0] RELOAD = 4'(REFILL_CYC - 1);

  logic [0:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [5:0]  sync1, sync2;
  logic [15:0] take_cnt;
  logic        take, eret;

  // Request decode; reset suppresses both so no pulse leaks out while rst=1.
  always_comb begin
    take = !rst && bus.cp0_go_handle && bus.m_valid;
    eret = !rst && bus.m_valid && bus.m_is_eret &&
           (bus.m_exc_code == 5'd0) && !bus.cp0_go_handle;
  end

  // Pipeline control and CP0-facing outputs.
  always_comb begin
    bus.flush       = take || eret;
    bus.kill_m      = take;
    bus.redirect    = take || eret;
    bus.cp0_exlclr  = eret;
    bus.redirect_pc = eret ? bus.cp0_epc : HANDLER_ADDR;
    bus.cp0_exccode = bus.m_valid ? bus.m_exc_code : 5'd0;
    bus.cp0_hwint   = (!rst && state == RUN && bus.m_valid) ? sync2 : '0;
    bus.take_count  = take_cnt;
  end

  // Blackout sequencing: any redirect (re)starts the REFILL countdown.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (take || eret) begin
      state_nxt = REFILL;
      cnt_nxt   = RELOAD;
    end else if (state == REFILL) begin
      if (cnt == 4'd0) state_nxt = RUN;
      else             cnt_nxt   = cnt - 4'd1;
    end
  end

  // State, synchronizer and take counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      sync1    <= '0;
      sync2    <= '0;
      take_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sync1 <= bus.hw_irq;
      sync2 <= sync1;
      if (take && take_cnt != '1) take_cnt <= take_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: reference model of redirects, blackout and counting,
// compared every cycle, plus directed literal checks.
module tb_exc_ctrl;
  localparam logic [31:0] H = 32'h0000_4180;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  exc_ctrl_if bus();

  exc_ctrl #(.HANDLER_ADDR(H), .REFILL_CYC(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: blackout = cycles of interrupt masking still owed,
  // irq_d1/irq_d2 = interrupt level seen one/two edges ago.
  int          blackout = 0;
  int          count    = 0;
  logic [5:0]  irq_d1   = '0;
  logic [5:0]  irq_d2   = '0;

  function automatic bit m_take();
    return !rst && bus.cp0_go_handle && bus.m_valid;
  endfunction

  function automatic bit m_eret();
    return !rst && bus.m_valid && bus.m_is_eret && bus.m_exc_code == 5'd0 &&
           !bus.cp0_go_handle;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      blackout = 0;
      count    = 0;
      irq_d1   = '0;
      irq_d2   = '0;
    end else begin
      if (m_take() && count < 65535) count = count + 1;
      if (m_take() || m_eret()) blackout = 3;
      else if (blackout > 0)    blackout = blackout - 1;
      irq_d2 = irq_d1;
      irq_d1 = bus.hw_irq;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit t, e;
      t = m_take();
      e = m_eret();
      chk("flush",       32'(bus.flush),       32'(t | e));
      chk("kill_m",      32'(bus.kill_m),      32'(t));
      chk("redirect",    32'(bus.redirect),    32'(t | e));
      chk("cp0_exlclr",  32'(bus.cp0_exlclr),  32'(e));
      chk("redirect_pc", bus.redirect_pc,      (e && !t) ? bus.cp0_epc : H);
      chk("cp0_exccode", 32'(bus.cp0_exccode), bus.m_valid ? 32'(bus.m_exc_code) : 32'd0);
      chk("cp0_hwint",   32'(bus.cp0_hwint),
          (!rst && blackout == 0 && bus.m_valid) ? 32'(irq_d2) : 32'd0);
      chk("take_count",  32'(bus.take_count),  32'(count));
    end
  end

  task automatic step(input logic v, input logic [4:0] code, input logic er,
                      input logic go, input logic [31:0] epc, input logic [5:0] irq,
                      input logic r);
    @(posedge clk);
    #1;
    bus.m_valid       = v;
    bus.m_exc_code    = code;
    bus.m_is_eret     = er;
    bus.cp0_go_handle = go;
    bus.cp0_epc       = epc;
    bus.hw_irq        = irq;
    rst               = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.m_valid = 1'b0; bus.m_exc_code = '0; bus.m_is_eret = 1'b0;
    bus.cp0_go_handle = 1'b0; bus.cp0_epc = '0; bus.hw_irq = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // reset state
    step(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1);
    chk("rst_take_count", 32'(bus.take_count), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);

    // synchronizer latency
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'b000100, 1'b0);
    chk("sync_lat0", 32'(bus.cp0_hwint), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'b000100, 1'b0);
    chk("sync_lat1", 32'(bus.cp0_hwint), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'b000100, 1'b0);
    chk("sync_lat2", 32'(bus.cp0_hwint), 32'h04);

    // bubble gating
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    chk("bubble_hwint", 32'(bus.cp0_hwint), 32'd0);
    chk("bubble_flush", 32'(bus.flush), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    chk("valid_hwint", 32'(bus.cp0_hwint), 32'h01);

    // exception take and blackout
    step(1'b1, 5'd4, 1'b0, 1'b1, 32'h0, 6'h01, 1'b0);
    chk("take_exccode", 32'(bus.cp0_exccode), 32'd4);
    chk("take_kill", 32'({bus.kill_m, bus.flush, bus.redirect}), 32'b111);
    chk("take_pc", bus.redirect_pc, 32'h4180);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    chk("take_count1", 32'(bus.take_count), 32'd1);
    chk("blackout1", 32'(bus.cp0_hwint), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    chk("blackout3", 32'(bus.cp0_hwint), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h01, 1'b0);
    chk("blackout_end", 32'(bus.cp0_hwint), 32'h01);

    // eret
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    step(1'b1, 5'd0, 1'b1, 1'b0, 32'h3010, 6'h3F, 1'b0);
    chk("eret_pc", bus.redirect_pc, 32'h3010);
    chk("eret_exlclr", 32'(bus.cp0_exlclr), 32'd1);
    chk("eret_kill", 32'(bus.kill_m), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
      chk("eret_blackout", 32'(bus.cp0_hwint), 32'd0);
    end
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    chk("eret_run", 32'(bus.cp0_hwint), 32'h3F);

    // eret disqualified by a pending exception code or a bubble
    step(1'b1, 5'd12, 1'b1, 1'b0, 32'h3010, 6'h3F, 1'b0);
    chk("eret_code_flush", 32'(bus.flush), 32'd0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 32'h3010, 6'h3F, 1'b0);
    chk("eret_bubble_flush", 32'(bus.flush), 32'd0);

    // take inside REFILL reloads the blackout
    step(1'b1, 5'd0, 1'b0, 1'b1, 32'h0, 6'h3F, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b1, 32'h0, 6'h3F, 1'b0);
    chk("retake_flush", 32'(bus.flush), 32'd1);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    chk("retake_blackout", 32'(bus.cp0_hwint), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    chk("retake_run", 32'(bus.cp0_hwint), 32'h3F);
    chk("take_count3", 32'(bus.take_count), 32'd3);

    // take beats eret
    step(1'b1, 5'd0, 1'b1, 1'b1, 32'h3010, 6'h3F, 1'b0);
    chk("prio_pc", bus.redirect_pc, 32'h4180);
    chk("prio_exlclr", 32'(bus.cp0_exlclr), 32'd0);
    chk("prio_kill", 32'(bus.kill_m), 32'd1);

    // reset right after a take
    step(1'b1, 5'd0, 1'b0, 1'b1, 32'h0, 6'h3F, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b1, 32'h0, 6'h3F, 1'b1);
    chk("rstpulse_ctrl",
        32'({bus.flush, bus.kill_m, bus.redirect, bus.cp0_exlclr}), 32'd0);
    chk("rstpulse_hwint", 32'(bus.cp0_hwint), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    chk("rstpulse_count", 32'(bus.take_count), 32'd0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0);
    chk("rstpulse_run", 32'(bus.cp0_hwint), 32'h3F);

    // saturation of take_count
    step(1'b1, 5'd0, 1'b0, 1'b1, 32'h0, 6'h00, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_count", 32'(bus.take_count), 32'h0000_FFFF);
    step(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0);
    chk("sat_hold", 32'(bus.take_count), 32'h0000_FFFF);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_4180: exception/interrupt handler entry PC.
REQ-002 SHALL have parameter REFILL_CYC, default 3: interrupt blackout length after a redirect, range 1..15.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port hw_irq  in  6  asynchronous device interrupt levels.
REQ-006 SHALL have port m_valid  in  1  M stage holds a real instruction (not a bubble).
REQ-007 SHALL have port m_exc_code  in  5  exception code carried to M; 0 = none.
REQ-008 SHALL have port m_is_eret  in  1  M instruction is ERET.
REQ-009 SHALL have port cp0_go_handle  in  1  CP0 request-taken indication (interrupt or exception).
REQ-010 SHALL have port cp0_epc  in  32  current CP0 EPC value.
REQ-011 SHALL have port cp0_hwint  out  6  gated, synchronized interrupt lines to CP0.
REQ-012 SHALL have port cp0_exccode  out  5  exception code to CP0.
REQ-013 SHALL have port cp0_exlclr  out  1  EXL clear pulse to CP0.
REQ-014 SHALL have port flush  out  1  clear F/D/E/M pipeline registers at this edge.
REQ-015 SHALL have port kill_m  out  1  suppress all M/W side effects of the current M instruction.
REQ-016 SHALL have port redirect  out  1  PC loads redirect_pc at this edge.
REQ-017 SHALL have port redirect_pc  out  32  redirect target.
REQ-018 SHALL have port take_count  out  16  saturating count of handled exceptions/interrupts.

Function
REQ-019 SHALL synchronize hw_irq through two flops (sync1, sync2); sync2 is the synchronized level, latency 2 cycles.
REQ-020 SHALL drive cp0_hwint = sync2 when state=RUN and m_valid=1, else 6'b0 (no interrupt taken on a bubble or during blackout).
REQ-021 SHALL drive cp0_exccode = m_valid ? m_exc_code : 0.
REQ-022 SHALL define states RUN and REFILL plus a 4-bit blackout counter cnt.
REQ-023 "take" condition: cp0_go_handle=1 and m_valid=1, evaluated in any state; SHALL assert kill_m, flush, redirect combinationally in the same cycle with redirect_pc=HANDLER_ADDR.
REQ-024 "eret" condition: m_valid=1, m_is_eret=1, m_exc_code=0, cp0_go_handle=0; SHALL assert flush, redirect, cp0_exlclr in the same cycle with redirect_pc=cp0_epc; kill_m=0.
REQ-025 take SHALL win over eret in the same cycle; cp0_exlclr=0 then.
REQ-026 On take or eret, next state SHALL be REFILL with cnt loaded to REFILL_CYC-1.
REQ-027 In REFILL with no take/eret, cnt SHALL decrement; at cnt=0 next state SHALL be RUN.
REQ-028 take/eret in REFILL SHALL reload cnt and remain in REFILL.
REQ-029 With neither condition, flush, kill_m, redirect, cp0_exlclr SHALL be 0 and redirect_pc SHALL be HANDLER_ADDR.
REQ-030 take_count SHALL increment by 1 on each take cycle, holding at 16'hFFFF.

Reset
REQ-031 While rst=1: state=RUN, cnt=0, sync1=sync2=0, take_count=0; flush, kill_m, redirect, cp0_exlclr forced 0; cp0_hwint=0.
REQ-032 rst asserted in REFILL SHALL return to RUN on the next edge, discarding the remaining blackout.

Verification
REQ-033 hw_irq=6'b000100 rises at edge E, m_valid=1, RUN -> cp0_hwint=6'b000100 after edge E+2; no earlier.
REQ-034 cp0_go_handle=1, m_valid=1, m_exc_code=5'd4 -> same cycle cp0_exccode=4, kill_m=flush=redirect=1, redirect_pc=32'h4180; take_count +1; REFILL for 3 cycles.
REQ-035 m_is_eret=1, m_valid=1, cp0_epc=32'h3010 -> same cycle redirect_pc=32'h3010, cp0_exlclr=1, kill_m=0; during next 3 cycles cp0_hwint=0 even with sync2=6'h3F.
REQ-036 sync2=6'h01, m_valid=0 -> cp0_hwint=0, no flush; m_valid returns 1 -> cp0_hwint=6'h01.
REQ-037 m_is_eret=1 with cp0_go_handle=1 -> redirect_pc=32'h4180, cp0_exlclr=0; 65540 takes -> take_count=16'hFFFF.
REQ-038 rst pulsed 1 cycle after a take -> state RUN, take_count=0, all pulse outputs 0.
